seq_control_unit: RTL and testbench
===================================

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of prioritised interrupt lines (1..8).
REQ-002 SHALL have parameter IRQ_W, default 2, width of interrupt index (ceil log2 NUM_IRQ, min 1).
REQ-003 SHALL have parameter DIV_TIMEOUT, default 31, max cycles waited for alu_done.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, max cycles waited for mem_ready.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk in 1 rising-edge clock; rst_n in 1 async active-low reset.
REQ-006 SHALL have ports: instr in 16 instruction word; i_valid in 1 instr valid; i_req out 1 fetch request.
REQ-007 SHALL have ports: reg1_addr out 4, reg2_addr out 4 read addresses; wb_addr out 4; wb_en out 1; wb_src out 2 (0 ALU, 1 mem, 2 imm-high, 3 imm-low); imm out 8.
REQ-008 SHALL have ports: alu_op out 4; alu_start out 1 multi-cycle start pulse; alu_done in 1.
REQ-009 SHALL have ports: mem_rd out 1; mem_wr out 1; mem_ready in 1; pc_inc out 1; pc_load out 1; flags in 3 ([0] eq, [1] gt, [2] int mask).
REQ-010 SHALL have ports: irq in NUM_IRQ; irq_ack out 1; irq_idx out IRQ_W; halted out 1; timeout_err out 1 sticky.

Function
REQ-011 SHALL implement states FETCH, DECODE, ALU_WAIT, MEM_WAIT, WRITEBACK, INT_ENTRY, HALT; all strobes default 0 each cycle unless stated.
REQ-012 FETCH: if irq!=0 and flags[2]=0, go INT_ENTRY; else assert i_req and remain until i_valid=1, then pulse pc_inc and go DECODE.
REQ-013 Interrupt priority: lowest-numbered set irq bit wins; irq_idx latched in FETCH, held until next INT_ENTRY.
REQ-014 INT_ENTRY: one cycle; pulse irq_ack and pc_load; next FETCH; interrupts checked only in FETCH, never mid-instruction.
REQ-015 DECODE, opcode instr[15:12] in 0x1-0x3, 0x6-0xA: reg1_addr=instr[11:8], reg2_addr=instr[7:4], alu_op=opcode, wb_addr=instr[3:0], wb_src=0; next WRITEBACK.
REQ-016 DECODE, opcode 0x4 or 0x5: same addressing, pulse alu_start one cycle; next ALU_WAIT with counter loaded to DIV_TIMEOUT.
REQ-017 ALU_WAIT: alu_done=1 -> WRITEBACK (wb_src=0) same cycle it is seen; counter reaches 0 without alu_done -> set timeout_err, go HALT.
REQ-018 DECODE, opcode 0xB/0xC: imm=instr[7:0], wb_addr=instr[11:8], wb_src=2/3; next WRITEBACK.
REQ-019 DECODE, instr[15:8]=0xF4 (load): reg2_addr=instr[7:4], wb_addr=instr[3:0], mem_rd held; 0xF5 (store): reg1_addr=instr[7:4], reg2_addr=instr[3:0], mem_wr held; both go MEM_WAIT with counter=MEM_TIMEOUT.
REQ-020 MEM_WAIT: mem_rd/mem_wr stay asserted until mem_ready=1; load then WRITEBACK (wb_src=1), store then FETCH; timeout sets timeout_err, go HALT.
REQ-021 DECODE, 0xF3 (jump): reg1_addr=instr[3:0]; pc_load=1 iff (instr[4]&flags[0]) | (instr[5]&~flags[1]&~flags[0]) | (instr[6]&flags[1]&~flags[0]) | instr[7]; next FETCH.
REQ-022 DECODE, 0xFFFF: nop, next FETCH; any other encoding incl. opcode 0x0 -> HALT.
REQ-023 WRITEBACK: wb_en=1 exactly one cycle with wb_addr/wb_src stable; next FETCH.
REQ-024 HALT: halted=1, all strobes 0, irq ignored; exit only by reset.
REQ-025 Counters SHALL be wide enough for the parameters and SHALL not wrap; mem_ready and alu_done ignored outside their wait states.

Reset
REQ-026 rst_n=0 SHALL immediately force state FETCH, all outputs 0, irq_idx=0, timeout_err=0, counters 0, regardless of current state, including mid-wait.
REQ-027 First i_req SHALL assert the first rising clk after rst_n deasserts.

Verification
REQ-028 instr=0x1234, i_valid=1 -> DECODE reg1=2, reg2=3, alu_op=1; next cycle wb_en=1, wb_addr=4, wb_src=0.
REQ-029 instr=0x4AB5, alu_done at 5th ALU_WAIT cycle -> alu_start one pulse, wb_en once with wb_addr=5; alu_done never -> timeout_err=1, halted=1 after 32 wait cycles.
REQ-030 irq=4'b0110, flags[2]=0 in FETCH -> INT_ENTRY, irq_idx=1, irq_ack and pc_load one cycle; flags[2]=1 -> normal fetch.
REQ-031 instr=0xF412, mem_ready after 3 cycles -> mem_rd held 3 cycles, then wb_en, wb_addr=2, wb_src=1.
REQ-032 instr=0xF3 with bit4=1, flags=3'b001 -> pc_load=1; flags=3'b010 -> pc_load=0; rst_n pulsed in MEM_WAIT -> outputs 0 immediately.

Source files
------------

// File: rtl/seq_control_unit.sv
// seq_control_unit -- sequencer for a small 16-bit instruction set.
//
// Fetches one instruction at a time, decodes it into register-file,
// ALU, memory and PC control strobes, waits (with bounded timeouts) on
// multi-cycle ALU ops and memory accesses, and takes prioritised
// interrupts between instructions.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   instr, i_valid, i_req instruction fetch handshake
//   reg1_addr, reg2_addr  register read addresses
//   wb_addr, wb_en,       register write-back (wb_src: 0 ALU, 1 mem,
//   wb_src, imm           2 imm-high, 3 imm-low), 8-bit immediate
//   alu_op, alu_start,    ALU operation, multi-cycle start pulse, done
//   alu_done
//   mem_rd, mem_wr,       memory strobes (held until mem_ready)
//   mem_ready
//   pc_inc, pc_load       program-counter control
//   flags                 [0] eq, [1] gt, [2] interrupt mask
//   irq, irq_ack, irq_idx interrupt lines, acknowledge, winning index
//   halted, timeout_err   halt indication, sticky wait-timeout flag
module seq_control_unit #(
    parameter int NUM_IRQ     = 4,
    parameter int IRQ_W       = 2,
    parameter int DIV_TIMEOUT = 31,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        instr,
    input  logic               i_valid,
    output logic               i_req,
    output logic [3:0]         reg1_addr,
    output logic [3:0]         reg2_addr,
    output logic [3:0]         wb_addr,
    output logic               wb_en,
    output logic [1:0]         wb_src,
    output logic [7:0]         imm,
    output logic [3:0]         alu_op,
    output logic               alu_start,
    input  logic               alu_done,
    output logic               mem_rd,
    output logic               mem_wr,
    input  logic               mem_ready,
    output logic               pc_inc,
    output logic               pc_load,
    input  logic [2:0]         flags,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               irq_ack,
    output logic [IRQ_W-1:0]   irq_idx,
    output logic               halted,
    output logic               timeout_err
);

    localparam int MAX_TO = (DIV_TIMEOUT > MEM_TIMEOUT) ? DIV_TIMEOUT : MEM_TIMEOUT;
    localparam int CNT_W  = (MAX_TO < 1) ? 1 : $clog2(MAX_TO + 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_ALU_WAIT, S_MEM_WAIT, S_WRITEBACK, S_INT_ENTRY, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_MULTI, C_IMM_HI, C_IMM_LO, C_LOAD, C_STORE, C_JUMP, C_NOP, C_ILLEGAL
    } iclass_t;

    state_t             state, state_n;
    iclass_t            iclass;
    logic [15:0]        ir;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IRQ_W-1:0]   irq_sel;
    logic               run;        // low for the first cycle after reset
    logic               load_ir, take_irq, set_to, jump_taken;

    // Instruction class from the latched instruction word.
    always_comb begin
        iclass = C_ILLEGAL;
        case (ir[15:12])
            4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA: iclass = C_ALU;
            4'h4, 4'h5: iclass = C_MULTI;
            4'hB:       iclass = C_IMM_HI;
            4'hC:       iclass = C_IMM_LO;
            4'hF: begin
                if (ir == 16'hFFFF)        iclass = C_NOP;
                else if (ir[11:8] == 4'h4) iclass = C_LOAD;
                else if (ir[11:8] == 4'h5) iclass = C_STORE;
                else if (ir[11:8] == 4'h3) iclass = C_JUMP;
            end
            default: iclass = C_ILLEGAL;
        endcase
    end

    assign jump_taken = (ir[4] & flags[0])
                      | (ir[5] & ~flags[1] & ~flags[0])
                      | (ir[6] &  flags[1] & ~flags[0])
                      |  ir[7];

    // Lowest-numbered pending line wins: scan from the top so the last
    // hit is the smallest index.
    always_comb begin
        irq_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) irq_sel = IRQ_W'(i);
        end
    end

    // Operand fields stay valid for the whole life of the instruction so
    // write-back sees stable wb_addr/wb_src.
    always_comb begin
        reg1_addr = '0;
        reg2_addr = '0;
        alu_op    = '0;
        wb_addr   = '0;
        wb_src    = '0;
        imm       = '0;
        if (state inside {S_DECODE, S_ALU_WAIT, S_MEM_WAIT, S_WRITEBACK}) begin
            case (iclass)
                C_ALU, C_MULTI: begin
                    reg1_addr = ir[11:8];
                    reg2_addr = ir[7:4];
                    alu_op    = ir[15:12];
                    wb_addr   = ir[3:0];
                    wb_src    = 2'd0;
                end
                C_IMM_HI, C_IMM_LO: begin
                    imm     = ir[7:0];
                    wb_addr = ir[11:8];
                    wb_src  = (iclass == C_IMM_HI) ? 2'd2 : 2'd3;
                end
                C_LOAD: begin
                    reg2_addr = ir[7:4];
                    wb_addr   = ir[3:0];
                    wb_src    = 2'd1;
                end
                C_STORE: begin
                    reg1_addr = ir[7:4];
                    reg2_addr = ir[3:0];
                end
                C_JUMP:  reg1_addr = ir[3:0];
                default: ;
            endcase
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        i_req     = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        alu_start = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        wb_en     = 1'b0;
        irq_ack   = 1'b0;
        halted    = 1'b0;
        load_ir   = 1'b0;
        take_irq  = 1'b0;
        set_to    = 1'b0;
        case (state)
            S_FETCH: begin
                if (run) begin
                    if ((|irq) && !flags[2]) begin
                        take_irq = 1'b1;
                        state_n  = S_INT_ENTRY;
                    end else begin
                        i_req = 1'b1;
                        if (i_valid) begin
                            pc_inc  = 1'b1;
                            load_ir = 1'b1;
                            state_n = S_DECODE;
                        end
                    end
                end
            end
            S_DECODE: begin
                case (iclass)
                    C_ALU, C_IMM_HI, C_IMM_LO: state_n = S_WRITEBACK;
                    C_MULTI: begin
                        alu_start = 1'b1;
                        cnt_n     = CNT_W'(DIV_TIMEOUT);
                        state_n   = S_ALU_WAIT;
                    end
                    C_LOAD, C_STORE: begin
                        mem_rd  = (iclass == C_LOAD);
                        mem_wr  = (iclass == C_STORE);
                        cnt_n   = CNT_W'(MEM_TIMEOUT);
                        state_n = S_MEM_WAIT;
                    end
                    C_JUMP: begin
                        pc_load = jump_taken;
                        state_n = S_FETCH;
                    end
                    C_NOP:   state_n = S_FETCH;
                    default: state_n = S_HALT;
                endcase
            end
            S_ALU_WAIT: begin
                // Done is honoured even on the last (count 0) cycle.
                if (alu_done) begin
                    state_n = S_WRITEBACK;
                end else if (cnt == '0) begin
                    set_to  = 1'b1;
                    state_n = S_HALT;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                mem_rd = (iclass == C_LOAD);
                mem_wr = (iclass == C_STORE);
                if (mem_ready) begin
                    state_n = (iclass == C_LOAD) ? S_WRITEBACK : S_FETCH;
                end else if (cnt == '0) begin
                    set_to  = 1'b1;
                    state_n = S_HALT;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_WRITEBACK: begin
                wb_en   = 1'b1;
                state_n = S_FETCH;
            end
            S_INT_ENTRY: begin
                irq_ack = 1'b1;
                pc_load = 1'b1;
                state_n = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_n = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            cnt         <= '0;
            ir          <= '0;
            irq_idx     <= '0;
            timeout_err <= 1'b0;
            run         <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_n;
            cnt   <= cnt_n;
            if (load_ir)  ir          <= instr;
            if (take_irq) irq_idx     <= irq_sel;
            if (set_to)   timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit. Each directed scenario drives
// inputs cycle by cycle and states what every output must be in that
// cycle, derived from the instruction-set rules; a single compare process
// checks the full output vector on every falling edge. Literal checks on
// captured cycles pin the expectations to hand-computed values.
module tb_seq_control_unit;

    localparam int NUM_IRQ     = 4;
    localparam int IRQ_W       = 2;
    localparam int DIV_TIMEOUT = 31;
    localparam int MEM_TIMEOUT = 15;

    typedef struct packed {
        logic             i_req;
        logic             pc_inc;
        logic             pc_load;
        logic             wb_en;
        logic             alu_start;
        logic             mem_rd;
        logic             mem_wr;
        logic             irq_ack;
        logic             halted;
        logic             timeout_err;
        logic [3:0]       reg1;
        logic [3:0]       reg2;
        logic [3:0]       wb_addr;
        logic [3:0]       alu_op;
        logic [1:0]       wb_src;
        logic [7:0]       imm;
        logic [IRQ_W-1:0] irq_idx;
    } out_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [15:0]        instr;
    logic               i_valid, i_req;
    logic [3:0]         reg1_addr, reg2_addr, wb_addr, alu_op;
    logic               wb_en, alu_start, alu_done;
    logic [1:0]         wb_src;
    logic [7:0]         imm;
    logic               mem_rd, mem_wr, mem_ready, pc_inc, pc_load;
    logic [2:0]         flags;
    logic [NUM_IRQ-1:0] irq;
    logic               irq_ack, halted, timeout_err;
    logic [IRQ_W-1:0]   irq_idx;

    seq_control_unit #(
        .NUM_IRQ(NUM_IRQ), .IRQ_W(IRQ_W),
        .DIV_TIMEOUT(DIV_TIMEOUT), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr(instr), .i_valid(i_valid), .i_req(i_req),
        .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
        .wb_addr(wb_addr), .wb_en(wb_en), .wb_src(wb_src), .imm(imm),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
        .pc_inc(pc_inc), .pc_load(pc_load), .flags(flags),
        .irq(irq), .irq_ack(irq_ack), .irq_idx(irq_idx),
        .halted(halted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    out_t act, exp, snap;
    bit   check_en = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    // Model-side persistent state.
    logic [IRQ_W-1:0] m_irq_idx = '0;
    logic             m_to      = 1'b0;

    // Scenario results for literal checks.
    out_t g_dec, g_wb;
    int   g_starts, g_wbs, g_rd;

    always_comb begin
        act             = '0;
        act.i_req       = i_req;
        act.pc_inc      = pc_inc;
        act.pc_load     = pc_load;
        act.wb_en       = wb_en;
        act.alu_start   = alu_start;
        act.mem_rd      = mem_rd;
        act.mem_wr      = mem_wr;
        act.irq_ack     = irq_ack;
        act.halted      = halted;
        act.timeout_err = timeout_err;
        act.reg1        = reg1_addr;
        act.reg2        = reg2_addr;
        act.wb_addr     = wb_addr;
        act.alu_op      = alu_op;
        act.wb_src      = wb_src;
        act.imm         = imm;
        act.irq_idx     = irq_idx;
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_compare @%0t actual=%h expected=%h", $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One clock cycle: publish the expectation, sample at the falling
    // edge, return just after the next rising edge.
    task automatic cyc(input out_t e);
        exp      = e;
        check_en = 1'b1;
        @(negedge clk);
        snap = act;
        @(posedge clk);
        #1;
    endtask

    function automatic out_t base();
        out_t o = '0;
        o.irq_idx     = m_irq_idx;
        o.timeout_err = m_to;
        return o;
    endfunction

    function automatic int lowest_set(input logic [NUM_IRQ-1:0] v);
        for (int i = 0; i < NUM_IRQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Operand fields an instruction presents while it is in flight.
    function automatic out_t fields(input logic [15:0] ins);
        out_t       o  = base();
        logic [3:0] op = ins[15:12];
        if (op inside {[4'h1:4'hA]}) begin
            o.reg1 = ins[11:8]; o.reg2 = ins[7:4]; o.alu_op = op;
            o.wb_addr = ins[3:0]; o.wb_src = 2'd0;
        end else if (op == 4'hB || op == 4'hC) begin
            o.imm = ins[7:0]; o.wb_addr = ins[11:8];
            o.wb_src = (op == 4'hB) ? 2'd2 : 2'd3;
        end else if (ins[15:8] == 8'hF4) begin
            o.reg2 = ins[7:4]; o.wb_addr = ins[3:0]; o.wb_src = 2'd1;
        end else if (ins[15:8] == 8'hF5) begin
            o.reg1 = ins[7:4]; o.reg2 = ins[3:0];
        end else if (ins[15:8] == 8'hF3) begin
            o.reg1 = ins[3:0];
        end
        return o;
    endfunction

    function automatic logic jump_rule(input logic [15:0] ins, input logic [2:0] fl);
        logic eq = fl[0], gt = fl[1];
        return (ins[4] && eq) || (ins[5] && !gt && !eq) || (ins[6] && gt && !eq) || ins[7];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        m_irq_idx = '0;
        m_to = 1'b0;
        instr = '0; i_valid = 0; alu_done = 0; mem_ready = 0; flags = '0; irq = '0;
        cyc(base());
        cyc(base());
        rst_n = 1'b1;
        cyc(base());   // no fetch request until the first edge after release
    endtask

    task automatic fetch(input logic [15:0] ins);
        out_t e = base();
        instr = ins; i_valid = 1'b1;
        e.i_req = 1'b1; e.pc_inc = 1'b1;
        cyc(e);
        i_valid = 1'b0; instr = 16'h0000;
    endtask

    // Single-cycle ALU and immediate instructions: decode then write-back.
    task automatic run_simple(input logic [15:0] ins);
        out_t e;
        fetch(ins);
        cyc(fields(ins)); g_dec = snap;
        e = fields(ins); e.wb_en = 1'b1;
        cyc(e); g_wb = snap;
    endtask

    // done_at: ALU_WAIT cycle (1-based) where alu_done is raised; 0 = never.
    task automatic run_multi(input logic [15:0] ins, input int done_at);
        out_t e;
        fetch(ins);
        e = fields(ins); e.alu_start = 1'b1;
        cyc(e); g_starts = int'(snap.alu_start); g_wbs = 0;
        mem_ready = 1'b1;   // irrelevant while waiting on the ALU
        for (int k = 1; k <= DIV_TIMEOUT + 1; k++) begin
            alu_done = (k == done_at);
            cyc(fields(ins));
            g_starts += int'(snap.alu_start);
            if (k == done_at) break;
        end
        alu_done = 1'b0; mem_ready = 1'b0;
        if (done_at >= 1 && done_at <= DIV_TIMEOUT + 1) begin
            e = fields(ins); e.wb_en = 1'b1;
            cyc(e); g_wb = snap; g_wbs += int'(snap.wb_en);
        end else begin
            m_to = 1'b1;
            e = base(); e.halted = 1'b1;
            cyc(e); g_wb = snap;
        end
    endtask

    // ready_at: MEM_WAIT cycle (1-based) where mem_ready is raised; 0 = never.
    task automatic run_mem(input logic [15:0] ins, input int ready_at);
        out_t e;
        logic is_load = (ins[15:8] == 8'hF4);
        fetch(ins);
        e = fields(ins); e.mem_rd = is_load; e.mem_wr = !is_load;
        cyc(e); g_dec = snap; g_rd = int'(snap.mem_rd) + int'(snap.mem_wr);
        alu_done = 1'b1;    // irrelevant while waiting on memory
        for (int k = 1; k <= MEM_TIMEOUT + 1; k++) begin
            mem_ready = (k == ready_at);
            cyc(e);
            g_rd += int'(snap.mem_rd) + int'(snap.mem_wr);
            if (k == ready_at) break;
        end
        mem_ready = 1'b0; alu_done = 1'b0;
        if (ready_at >= 1 && ready_at <= MEM_TIMEOUT + 1) begin
            if (is_load) begin
                e = fields(ins); e.wb_en = 1'b1;
                cyc(e); g_wb = snap;
            end
        end else begin
            m_to = 1'b1;
            e = base(); e.halted = 1'b1;
            cyc(e); g_wb = snap;
        end
    endtask

    task automatic run_jump(input logic [15:0] ins, input logic [2:0] fl);
        out_t e;
        flags = fl;
        fetch(ins);
        e = fields(ins); e.pc_load = jump_rule(ins, fl);
        cyc(e); g_dec = snap;
        flags = '0;
    endtask

    task automatic take_irq(input logic [NUM_IRQ-1:0] lines);
        out_t e;
        irq = lines; flags = 3'b000;
        cyc(base());              // FETCH diverts: no i_req
        irq = '0;
        m_irq_idx = IRQ_W'(lowest_set(lines));
        e = base(); e.irq_ack = 1'b1; e.pc_load = 1'b1;
        cyc(e); g_dec = snap;
    endtask

    task automatic halt_cycles(input int n);
        out_t e = base();
        e.halted = 1'b1;
        irq = 4'b0001;            // must be ignored in HALT
        for (int k = 0; k < n; k++) cyc(e);
        irq = '0;
    endtask

    initial begin
        out_t e;
        rst_n = 1'b0;
        instr = '0; i_valid = 0; alu_done = 0; mem_ready = 0; flags = '0; irq = '0;
        @(posedge clk); #1;

        // Reset state and first fetch request.
        do_reset();
        check("reset_release_no_i_req", snap, 64'h0);
        fetch(16'h1234);
        check("first_i_req", snap.i_req, 1);
        cyc(fields(16'h1234)); g_dec = snap;
        check("alu_reg1", g_dec.reg1, 2);
        check("alu_reg2", g_dec.reg2, 3);
        check("alu_op", g_dec.alu_op, 1);
        e = fields(16'h1234); e.wb_en = 1'b1;
        cyc(e);
        check("alu_wb_en", snap.wb_en, 1);
        check("alu_wb_addr", snap.wb_addr, 4);
        check("alu_wb_src", snap.wb_src, 0);

        // Other single-cycle patterns, with idle fetch cycles between.
        e = base(); e.i_req = 1'b1;
        cyc(e); cyc(e);
        run_simple(16'hA9F0);
        run_simple(16'hB7C5);
        check("immh_wb_addr", g_wb.wb_addr, 7);
        check("immh_imm", g_wb.imm, 8'hC5);
        check("immh_wb_src", g_wb.wb_src, 2);
        run_simple(16'hC312);
        check("imml_wb_src", g_wb.wb_src, 3);

        // Interrupts: priority, masking, no mid-instruction entry.
        take_irq(4'b0110);
        check("irq_idx_lowest", g_dec.irq_idx, 1);
        check("irq_ack", g_dec.irq_ack, 1);
        irq = 4'b1000; flags = 3'b100;
        fetch(16'hFFFF);
        check("masked_irq_fetches", snap.i_req, 1);
        cyc(fields(16'hFFFF));    // nop decode, interrupt still pending
        take_irq(4'b1000);
        check("irq_idx_high", g_dec.irq_idx, 3);

        // Multi-cycle ALU: done on 5th wait cycle, and on the last one.
        run_multi(16'h4AB5, 5);
        check("multi_start_pulses", g_starts, 1);
        check("multi_wb_count", g_wbs, 1);
        check("multi_wb_addr", g_wb.wb_addr, 5);
        run_multi(16'h5123, DIV_TIMEOUT + 1);
        check("multi_done_last_cycle", g_wb.wb_en, 1);

        // Conditional jumps.
        run_jump(16'hF312, 3'b001);
        check("jump_eq_taken", g_dec.pc_load, 1);
        run_jump(16'hF312, 3'b010);
        check("jump_eq_not_taken", g_dec.pc_load, 0);
        run_jump(16'hF320, 3'b000);
        run_jump(16'hF340, 3'b010);
        run_jump(16'hF340, 3'b011);
        run_jump(16'hF380, 3'b010);

        // Memory: store completing on the last allowed cycle, then a load.
        run_mem(16'hF5AB, MEM_TIMEOUT + 1);
        run_mem(16'hF412, 2);
        check("load_rd_cycles", g_rd, 3);
        check("load_wb_addr", g_wb.wb_addr, 2);
        check("load_wb_src", g_wb.wb_src, 1);

        // Reset asserted mid MEM_WAIT clears outputs at once.
        fetch(16'hF434);
        e = fields(16'hF434); e.mem_rd = 1'b1;
        cyc(e); cyc(e); cyc(e);
        check("pre_reset_mem_rd", act.mem_rd, 1);
        check_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", act, 64'h0);
        do_reset();
        fetch(16'h2345);
        check("i_req_after_midwait_reset", snap.i_req, 1);
        cyc(fields(16'h2345));
        e = fields(16'h2345); e.wb_en = 1'b1;
        cyc(e);

        // ALU timeout.
        run_multi(16'h5123, 0);
        check("alu_timeout_err", g_wb.timeout_err, 1);
        check("alu_timeout_halted", g_wb.halted, 1);
        halt_cycles(3);
        do_reset();

        // Memory timeout.
        run_mem(16'hF400, 0);
        check("mem_timeout_err", g_wb.timeout_err, 1);
        halt_cycles(2);
        do_reset();

        // Illegal encodings halt without a timeout.
        fetch(16'h0123);
        cyc(base());
        halt_cycles(2);
        check("illegal_op0_halted", snap.halted, 1);
        do_reset();
        fetch(16'hF7AA);
        cyc(base());
        halt_cycles(1);
        check("illegal_f7_halted", snap.halted, 1);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
